// File: rtl/four_bit_subtr.sv
// 4-bit registered subtractor: ripple chain of four full adders computing a + ~b + cin.
// Per-stage carries are registered alongside the difference so wider datapaths can chain it.
module four_bit_subtr (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic [3:0] c
);

    logic [3:0] b_inv;
    logic [3:0] sum_p0;
    logic [3:0] k_p0;
    logic       carry;

    function automatic logic majority(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    assign b_inv = ~b;

    always_comb begin
        sum_p0 = '0;
        k_p0   = '0;
        carry  = cin;
        for (int i = 0; i < 4; i++) begin
            sum_p0[i] = a[i] ^ b_inv[i] ^ carry;
            k_p0[i]   = majority(a[i], b_inv[i], carry);
            carry     = k_p0[i];
        end
    end

    // stage p0 -> registered outputs; reset clears both difference and carries
    always_ff @(posedge clk) begin
        if (rst) begin
            s <= 4'h0;
            c <= 4'h0;
        end else begin
            s <= sum_p0;
            c <= k_p0;
        end
    end

endmodule

// File: tb/tb_four_bit_subtr.sv
// Scoreboard bench for four_bit_subtr: expected {s,c} queued when inputs are driven,
// popped and compared one cycle later.
module tb_four_bit_subtr;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] s;
    logic [3:0] c;

    typedef struct {
        string      tag;
        logic [3:0] s_exp;
        logic [3:0] c_exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int        n_vec;
    int        n_fail;

    four_bit_subtr dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .cin (cin),
        .s   (s),
        .c   (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", tag, obs, exp_v);
        end
    endtask

    // Arithmetic reference: carry out of bit i is bit i+1 of the truncated sum.
    task automatic ref_model(input logic [3:0] av, input logic [3:0] bv, input logic ci,
                             output logic [3:0] s_r, output logic [3:0] c_r);
        int mask;
        int part;
        part = int'(av) + int'((~bv) & 4'hF) + int'(ci);
        s_r  = part[3:0];
        c_r  = '0;
        for (int i = 0; i < 4; i++) begin
            mask   = (1 << (i + 1)) - 1;
            part   = (int'(av) & mask) + (int'(~bv) & mask) + int'(ci);
            c_r[i] = part[i + 1];
        end
    endtask

    task automatic drain_one();
        sb_entry_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_vec({e.tag, ".s"}, s, e.s_exp);
            check_vec({e.tag, ".c"}, c, e.c_exp);
        end
    endtask

    // Called at a negedge: compare result of the previous vector, then drive the next.
    task automatic apply(input string tag, input logic r, input logic [3:0] av,
                         input logic [3:0] bv, input logic ci);
        sb_entry_t e;
        logic [3:0] s_r;
        logic [3:0] c_r;
        @(negedge clk);
        drain_one();
        rst = r;
        a   = av;
        b   = bv;
        cin = ci;
        ref_model(av, bv, ci, s_r, c_r);
        e.tag   = tag;
        e.s_exp = r ? 4'h0 : s_r;
        e.c_exp = r ? 4'h0 : c_r;
        sb_q.push_back(e);
    endtask

    task automatic apply_fixed(input string tag, input logic r, input logic [3:0] av,
                               input logic [3:0] bv, input logic ci,
                               input logic [3:0] s_req, input logic [3:0] c_req);
        sb_entry_t e;
        @(negedge clk);
        drain_one();
        rst = r;
        a   = av;
        b   = bv;
        cin = ci;
        e.tag   = tag;
        e.s_exp = s_req;
        e.c_exp = c_req;
        sb_q.push_back(e);
    endtask

    initial begin
        logic [8:0] v;
        n_vec  = 0;
        n_fail = 0;
        rst = 1'b1;
        a   = 4'hF;
        b   = 4'h0;
        cin = 1'b1;

        apply_fixed("rst0", 1'b1, 4'hF, 4'h0, 1'b1, 4'h0, 4'b0000);
        apply_fixed("rst1", 1'b1, 4'hF, 4'h0, 1'b1, 4'h0, 4'b0000);
        apply_fixed("post_rst", 1'b0, 4'hF, 4'h0, 1'b1, 4'hF, 4'b1111);
        apply_fixed("5m3", 1'b0, 4'd5, 4'd3, 1'b1, 4'b0010, 4'b1101);
        apply_fixed("3m5", 1'b0, 4'd3, 4'd5, 1'b1, 4'b1110, 4'b0011);
        apply_fixed("0m0_bin", 1'b0, 4'd0, 4'd0, 1'b0, 4'b1111, 4'b0000);
        apply_fixed("0m0", 1'b0, 4'd0, 4'd0, 1'b1, 4'b0000, 4'b1111);

        for (int i = 0; i < 512; i++) begin
            v = 9'(i);
            if (i == 200) begin
                apply("sweep_rst", 1'b1, v[4:1], v[8:5], v[0]);
            end
            apply($sformatf("sweep%0d", i), 1'b0, v[4:1], v[8:5], v[0]);
        end

        @(negedge clk);
        drain_one();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
